// File: rtl/dma_priority_arbiter_pkg.sv
// Shared DMA arbiter types: FSM state encoding and default channel count.
package DmaPackage;

    localparam int DMA_NUM_CH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_REQ   = 2'd1,
        ARB_GRANT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dma_priority_arbiter_rr_pick.sv
// Channel picker: lowest pending index, or first pending at/after topPtr when rotating.
// Latency: purely combinational.
// Backpressure: none; the result is only consumed when the caller latches a grant.
module dma_rr_pick
    import DmaPackage::*;
#(
    parameter int NUM_CH = DMA_NUM_CH_DEFAULT,
    parameter int CHW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CHW-1:0]    topPtr,
    input  logic              rotEn,
    output logic [CHW-1:0]    winner,
    output logic              any
);

    int             slot;
    logic [CHW-1:0] scanIdx;
    logic           found;

    assign any = |pending;

    // Walk NUM_CH slots starting at the effective pointer, wrapping modulo NUM_CH.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        slot    = 0;
        scanIdx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            slot = (rotEn ? int'(topPtr) : 0) + i;
            if (slot >= NUM_CH) begin
                slot = slot - NUM_CH;
            end
            scanIdx = slot[CHW-1:0];
            if (!found && pending[scanIdx]) begin
                winner = scanIdx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter owning the HRQ/HLDA handshake and a registered one-hot DACK.
// Latency: DREQ->HRQ 2 cycles, swReq->HRQ 1 cycle, HLDA->DACK 1 cycle.
// Backpressure: a grant holds until xferDone or HLDA drop; other requests wait.
module dma_priority_arbiter
    import DmaPackage::*;
#(
    parameter int NUM_CH = DMA_NUM_CH_DEFAULT,
    parameter int CHW    = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              HRQ,
    input  logic              HLDA,
    input  logic [NUM_CH-1:0] maskBits,
    input  logic [NUM_CH-1:0] swReq,
    input  logic              rotEn,
    input  logic              ctrlDisable,
    input  logic              dreqActiveLow,
    input  logic              dackActiveLow,
    input  logic              xferDone,
    output logic              grantValid,
    output logic [CHW-1:0]    grantCh
);

    arb_state_e        state;
    logic [NUM_CH-1:0] reqQ;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] ackVec;
    logic [CHW-1:0]    topPtr;
    logic [CHW-1:0]    nextPtr;
    logic [CHW-1:0]    winner;
    logic              anyPending;

    assign pending = ctrlDisable ? '0 : ((reqQ & ~maskBits) | swReq);
    assign nextPtr = (grantCh == CHW'(NUM_CH - 1)) ? '0 : grantCh + CHW'(1);
    assign DACK    = ackVec ^ {NUM_CH{dackActiveLow}};

    dma_rr_pick #(
        .NUM_CH (NUM_CH),
        .CHW    (CHW)
    ) picker (
        .pending (pending),
        .topPtr  (topPtr),
        .rotEn   (rotEn),
        .winner  (winner),
        .any     (anyPending)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= ARB_IDLE;
            HRQ        <= 1'b0;
            ackVec     <= '0;
            grantValid <= 1'b0;
            grantCh    <= '0;
            topPtr     <= '0;
            reqQ       <= '0;
        end else begin
            reqQ <= DREQ ^ {NUM_CH{dreqActiveLow}};

            // Only a completed service moves the pointer; an HLDA abort leaves it alone.
            if (!rotEn) begin
                topPtr <= '0;
            end else if (state == ARB_GRANT && xferDone) begin
                topPtr <= nextPtr;
            end

            case (state)
                ARB_IDLE: begin
                    if (anyPending) begin
                        state <= ARB_REQ;
                        HRQ   <= 1'b1;
                    end
                end
                ARB_REQ: begin
                    if (HLDA && anyPending) begin
                        state      <= ARB_GRANT;
                        grantCh    <= winner;
                        ackVec     <= NUM_CH'(1) << winner;
                        grantValid <= 1'b1;
                    end else if (!anyPending) begin
                        state <= ARB_IDLE;
                        HRQ   <= 1'b0;
                    end
                end
                ARB_GRANT: begin
                    if (xferDone || !HLDA) begin
                        state      <= ARB_IDLE;
                        HRQ        <= 1'b0;
                        ackVec     <= '0;
                        grantValid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    HRQ        <= 1'b0;
                    ackVec     <= '0;
                    grantValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: 4-channel vector table and hand sequences, 8-channel rotation and random model.
module tb_dma_priority_arbiter;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] dreq, mask, sw;
    logic       hlda, rotEn, ctrlDis, dreqLow, dackLow, xferDone;

    logic [3:0] dack4;
    logic       hrq4, gv4;
    logic [1:0] gch4;
    logic [7:0] dack8;
    logic       hrq8, gv8;
    logic [2:0] gch8;

    int checks = 0;
    int errors = 0;

    dma_priority_arbiter #(.NUM_CH(4)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(dreq[3:0]), .DACK(dack4), .HRQ(hrq4), .HLDA(hlda),
        .maskBits(mask[3:0]), .swReq(sw[3:0]), .rotEn(rotEn), .ctrlDisable(ctrlDis),
        .dreqActiveLow(dreqLow), .dackActiveLow(dackLow), .xferDone(xferDone),
        .grantValid(gv4), .grantCh(gch4)
    );

    dma_priority_arbiter #(.NUM_CH(8)) dut8 (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(dreq), .DACK(dack8), .HRQ(hrq8), .HLDA(hlda),
        .maskBits(mask), .swReq(sw), .rotEn(rotEn), .ctrlDisable(ctrlDis),
        .dreqActiveLow(dreqLow), .dackActiveLow(dackLow), .xferDone(xferDone),
        .grantValid(gv8), .grantCh(gch8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] dreq;
        logic [3:0] mask;
        logic [3:0] sw;
        logic       ctrlDis;
        logic       dreqLow;
        logic       dackLow;
        logic       expValid;
        logic [1:0] expCh;
        logic [3:0] expDack;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic clearInputs();
        dreq = '0; mask = '0; sw = '0; hlda = 1'b0; rotEn = 1'b0; ctrlDis = 1'b0;
        dreqLow = 1'b0; dackLow = 1'b0; xferDone = 1'b0;
    endtask

    task automatic doReset();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
    endtask

    initial begin
        // Model state for the 8-channel random run
        logic [7:0] mReq, pend, expDack;
        int mPhase, mCh, mTop, win, base, c, n;
        int nPhase, nCh, nTop;
        logic mHrq, nHrq;

        vecs[0] = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010};
        vecs[1] = '{4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1011};
        vecs[2] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[3] = '{4'b1111, 4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100};
        vecs[4] = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000};
        vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1111};
        vecs[6] = '{4'b1100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000};
        vecs[7] = '{4'b0000, 4'b1111, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001};
        vecs[8] = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[9] = '{4'b0111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000};

        clearInputs();
        RESET_N = 1'b0;
        tick();
        tick();

        // Table: fixed-priority pick, masking, software requests, polarity, disable
        for (int v = 0; v < 10; v++) begin
            clearInputs();
            dreq[3:0] = vecs[v].dreq;
            mask[3:0] = vecs[v].mask;
            sw[3:0]   = vecs[v].sw;
            ctrlDis   = vecs[v].ctrlDis;
            dreqLow   = vecs[v].dreqLow;
            dackLow   = vecs[v].dackLow;
            hlda      = 1'b1;
            doReset();
            chk($sformatf("v%0d_rst_hrq", v), hrq4, 0);
            chk($sformatf("v%0d_rst_gv", v), gv4, 0);
            chk($sformatf("v%0d_rst_dack", v), dack4, {4{vecs[v].dackLow}});
            repeat (4) tick();
            chk($sformatf("v%0d_hrq", v), hrq4, vecs[v].expValid);
            chk($sformatf("v%0d_gv", v), gv4, vecs[v].expValid);
            if (vecs[v].expValid) chk($sformatf("v%0d_ch", v), gch4, vecs[v].expCh);
            chk($sformatf("v%0d_dack", v), dack4, vecs[v].expDack);
        end

        // Fixed priority: service ends, at least one idle cycle, ch1 wins again
        clearInputs();
        doReset();
        dreq = 8'b1010; hlda = 1'b1;
        repeat (3) tick();
        chk("fix_ch", gch4, 1);
        chk("fix_dack", dack4, 4'b0010);
        xferDone = 1'b1;
        tick();
        xferDone = 1'b0;
        chk("fix_rel_hrq", hrq4, 0);
        chk("fix_rel_gv", gv4, 0);
        chk("fix_rel_dack", dack4, 0);
        tick();
        chk("fix_rereq_hrq", hrq4, 1);
        tick();
        chk("fix_regrant_gv", gv4, 1);
        chk("fix_regrant_ch", gch4, 1);

        // DREQ latency, withdraw before HLDA, swReq latency
        clearInputs();
        doReset();
        dreq = 8'b0001;
        tick();
        chk("lat_e0_hrq", hrq4, 0);
        tick();
        chk("lat_e1_hrq", hrq4, 1);
        dreq = '0;
        repeat (2) tick();
        chk("wd_hrq", hrq4, 0);
        chk("wd_gv", gv4, 0);
        chk("wd_dack", dack4, 0);
        sw = 8'b0010;
        tick();
        chk("sw_lat_hrq", hrq4, 1);

        // Abort on ch3 in rotating mode keeps the pointer
        clearInputs();
        doReset();
        rotEn = 1'b1; hlda = 1'b1; dreq = 8'b0010;
        repeat (3) tick();
        chk("ab_pre_ch", gch4, 1);
        xferDone = 1'b1; dreq = 8'b1000;
        tick();
        xferDone = 1'b0;
        chk("ab_ptr_after_done", dut4.topPtr, 2);
        repeat (2) tick();
        chk("ab_ch3", gch4, 3);
        hlda = 1'b0; dreq = 8'b0010;
        tick();
        chk("ab_gv", gv4, 0);
        chk("ab_dack", dack4, 0);
        chk("ab_hrq", hrq4, 0);
        chk("ab_ptr", dut4.topPtr, 2);

        // Reset mid-grant, then a fresh DREQ
        hlda = 1'b1;
        repeat (2) tick();
        chk("rm_ch1", gch4, 1);
        dackLow = 1'b1;
        RESET_N = 1'b0;
        tick();
        chk("rm_hrq", hrq4, 0);
        chk("rm_gv", gv4, 0);
        chk("rm_ptr", dut4.topPtr, 0);
        chk("rm_dack", dack4, 4'b1111);
        RESET_N = 1'b1; dackLow = 1'b0;
        tick();
        chk("rm_f0_hrq", hrq4, 0);
        tick();
        chk("rm_f1_hrq", hrq4, 1);

        // Rotation on 8 channels with all requests held
        clearInputs();
        doReset();
        rotEn = 1'b1; hlda = 1'b1; dreq = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            n = 0;
            while (gv8 !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            chk($sformatf("rot%0d_wait", k), gv8, 1);
            chk($sformatf("rot%0d_ch", k), gch8, k % 8);
            xferDone = 1'b1;
            tick();
            xferDone = 1'b0;
            chk($sformatf("rot%0d_ptr", k), dut8.topPtr, (k + 1) % 8);
        end

        // Random traffic against the reference model (8 channels)
        clearInputs();
        rotEn = 1'b1;
        doReset();
        mReq = '0; mPhase = 0; mCh = 0; mTop = 0; mHrq = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom % 4 == 0) dreq = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            if ($urandom % 32 == 0) mask = 8'($urandom_range(0, 255));
            sw = ($urandom % 16 == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            ctrlDis = ($urandom % 20 == 0);
            if ($urandom % 100 == 0) rotEn = ~rotEn;
            if ($urandom % 128 == 0) dreqLow = ~dreqLow;
            if ($urandom % 128 == 0) dackLow = ~dackLow;
            hlda = (mPhase == 0) ? ($urandom % 8 == 0) :
                   (mPhase == 1) ? ($urandom % 3 != 0) : ($urandom % 20 != 0);
            xferDone = (mPhase == 2) ? ($urandom % 4 == 0) : ($urandom % 32 == 0);

            pend = ctrlDis ? 8'h00 : ((mReq & ~mask) | sw);
            base = rotEn ? mTop : 0;
            win = -1;
            for (int i = 0; i < 8; i++) begin
                c = (base + i) % 8;
                if (win < 0 && pend[c]) win = c;
            end
            nPhase = mPhase; nCh = mCh; nHrq = mHrq;
            nTop = !rotEn ? 0 : ((mPhase == 2 && xferDone) ? (mCh + 1) % 8 : mTop);
            if (mPhase == 0) begin
                if (pend != 0) begin nPhase = 1; nHrq = 1'b1; end
            end else if (mPhase == 1) begin
                if (hlda && pend != 0) begin nPhase = 2; nCh = win; end
                else if (pend == 0) begin nPhase = 0; nHrq = 1'b0; end
            end else begin
                if (xferDone || !hlda) begin nPhase = 0; nHrq = 1'b0; end
            end
            tick();
            mReq = dreq ^ {8{dreqLow}};
            mPhase = nPhase; mCh = nCh; mTop = nTop; mHrq = nHrq;

            expDack = ((mPhase == 2) ? (8'h01 << mCh) : 8'h00) ^ {8{dackLow}};
            chk($sformatf("rnd%0d_hrq", cyc), hrq8, mHrq);
            chk($sformatf("rnd%0d_gv", cyc), gv8, (mPhase == 2));
            if (mPhase == 2) chk($sformatf("rnd%0d_ch", cyc), gch8, mCh);
            chk($sformatf("rnd%0d_dack", cyc), dack8, expDack);
            chk($sformatf("rnd%0d_ptr", cyc), dut8.topPtr, mTop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Parametrised channel arbiter for the DMA controller. It generalises the fixed four-channel priority logic to `NUM_CH` channels and owns the HRQ/HLDA bus handshake with a proper request/grant state machine. It drives a single registered DACK per grant and keeps a rotating-priority pointer that advances only on completed services. It sits between the register file (mask, request, command bits) and the transfer-timing FSM, which reports end of service on `xferDone`.

## Interface
- `NUM_CH`, default 4: number of DMA channels, 2..16.
- `CHW`, default `$clog2(NUM_CH)`: derived channel-index width. Never overridden.

Ports:
- `CLK`  in  1: single clock, all state on rising edge.
- `RESET_N`  in  1: reset, synchronous, active-low.
- `DREQ`  in  NUM_CH: device request lines, polarity per `dreqActiveLow`.
- `DACK`  out  NUM_CH: device acknowledge lines, polarity per `dackActiveLow`.
- `HRQ`  out  1: hold request to CPU, active-high.
- `HLDA`  in  1: hold acknowledge from CPU, active-high.
- `maskBits`  in  NUM_CH: 1 = channel hardware request masked.
- `swReq`  in  NUM_CH: software request bits. Not maskable.
- `rotEn`  in  1: 1 = rotating priority, 0 = fixed (channel 0 highest).
- `ctrlDisable`  in  1: controller disable. Blocks new arbitration.
- `dreqActiveLow`  in  1: DREQ polarity select.
- `dackActiveLow`  in  1: DACK polarity select.
- `xferDone`  in  1: one-cycle pulse from the timing FSM, end of current service (TC, EOP or single-transfer end).
- `grantValid`  out  1: a channel currently holds the grant.
- `grantCh`  out  CHW: index of the granted channel. Valid only while `grantValid`=1.

## Operation
- **Request sampling.** `reqQ <= DREQ ^ {NUM_CH{dreqActiveLow}}`, one flop stage.
- **Pending vector.** `pending = (reqQ & ~maskBits) | swReq`. Forced to 0 when `ctrlDisable`=1.
- **Priority pick.**
  - Fixed mode: lowest index set in `pending` wins.
  - Rotating mode: the first set bit at or after `topPtr`, scanning upward modulo NUM_CH, wins.
- **State machine.**
  - `ARB_IDLE`:
    - `pending`≠0 → `ARB_REQ`, HRQ←1.
  - `ARB_REQ`:
    - `HLDA`=1 and `pending`≠0 → `ARB_GRANT`. The winner is latched into `grantCh`, `ackVec` is set to one-hot(winner), and `grantValid`←1.
    - `pending`=0 → `ARB_IDLE`, HRQ←0. The request was withdrawn before HLDA.
  - `ARB_GRANT`:
    - `xferDone`=1 → `ARB_IDLE`. HRQ, `ackVec` and `grantValid` clear. In rotating mode, `topPtr ← (grantCh+1) mod NUM_CH`.
    - `HLDA`=0 without `xferDone` → `ARB_IDLE` (abort). Outputs clear and `topPtr` is unchanged.
    - Otherwise hold. Pending changes, `ctrlDisable` and mask writes do not preempt the grant.
- **Pointer.** `topPtr` is forced to 0 whenever `rotEn`=0. Switching to rotating mode therefore starts from channel 0.
- **DACK.** `DACK = ackVec ^ {NUM_CH{dackActiveLow}}`. This is the only combinational output path. At most one channel is active at a time.
- **Simultaneous events.** `xferDone` together with `HLDA`=0 counts as a completed service, so rotation updates.

## Timing
- **Reset.** With `RESET_N`=0 at an edge, after that edge:
  - state = `ARB_IDLE`, HRQ=0, `ackVec`=0, `grantValid`=0, `grantCh`=0, `topPtr`=0, `reqQ`=0.
  - DACK shows the inactive level for the current `dackActiveLow`.
  - Reset mid-grant drops DACK and HRQ at the next edge.
- **Request to HRQ.** DREQ active before edge e0 → HRQ high after e1 (2-cycle latency). For `swReq` the latency is 1 cycle.
- **HLDA to DACK.** HLDA sampled high at edge e → DACK, `grantValid` and `grantCh` valid after e.
- **Release.** `xferDone` at edge e → DACK and HRQ inactive after e. The earliest next HRQ is after e+1, which guarantees at least one idle cycle between services.

## Structure
- **Shared package `DmaPackage`:**
  - `arb_state_e` {`ARB_IDLE`, `ARB_REQ`, `ARB_GRANT`}.
  - localparam `DMA_NUM_CH_DEFAULT`=4.
- **Sub-module `dma_rr_pick`:** purely combinational picker with inputs `pending`, `topPtr`, `rotEn` and outputs `winner`[CHW], `any`. It is parametrised by NUM_CH and unit-testable on its own.

## Test plan
- **Fixed priority.** NUM_CH=4, `rotEn`=0, DREQ=4'b1010, active-high, HLDA tied high one cycle after HRQ → `grantCh`=1, DACK=4'b0010. After `xferDone`, the next grant is again ch1.
- **Rotation.** NUM_CH=8, `rotEn`=1, DREQ=8'hFF held, `xferDone` each grant → grants run 0,1,…,7,0. After each completed service `topPtr` = grant+1.
- **Polarity.** `dreqActiveLow`=1, `dackActiveLow`=1, DREQ=4'b1011 → ch2 granted, DACK=4'b1011. DACK is 4'b1111 while idle and during reset.
- **Mask vs software request.** `maskBits`=4'b1111, DREQ=4'b1111 → HRQ stays 0. Then `swReq`=4'b0100 → HRQ after 1 cycle, grant ch2.
- **Abort and withdraw.**
  - DREQ dropped in `ARB_REQ` before HLDA → HRQ falls, no DACK.
  - In `ARB_GRANT` on ch3 with `rotEn`=1, HLDA dropped → DACK inactive next cycle and `topPtr` unchanged.
- **Reset mid-grant.** `RESET_N`=0 while ch1 is granted → after the edge HRQ=0, `grantValid`=0, `topPtr`=0. A fresh DREQ then gives HRQ after 2 cycles.
